// File: rtl/uart_tx_buffer.sv
// Byte FIFO behind a small register-write port, drained as 8N1 UART frames on tx_o.
// The baud divisor is latched at each frame start, so BAUD writes never disturb a frame in flight.
module uart_tx_buffer #(
    parameter int CLK_DIV = 868,
    parameter int DEPTH   = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    wr_valid_i,
    input  logic [3:0]              wr_addr_i,
    input  logic [31:0]             wr_data_i,
    output logic                    wr_ready_o,
    output logic                    wr_err_o,
    output logic                    tx_o,
    output logic                    busy_o,
    output logic [$clog2(DEPTH):0]  level_o,
    output logic [1:0]              dbg_state_o
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_mem [DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic        r_en;
    logic        r_err;
    logic        r_tx;
    logic [15:0] r_baud;
    logic [15:0] r_div;
    logic [15:0] r_cnt;
    logic [7:0]  r_shift;
    logic [2:0]  r_bit_idx;

    logic        w_full;
    logic        w_empty;
    logic        w_acc;
    logic        w_wr_ctrl;
    logic        w_push;
    logic        w_wr_baud;
    logic        w_unmapped;
    logic        w_flush;
    logic        w_avail;
    logic        w_bit_end;
    logic        w_pop;
    logic        w_shift;
    logic        w_tx_nxt;
    logic [15:0] w_baud_wr;
    logic        w_unused;

    // Handshake: a write takes effect on a rising edge with wr_valid_i && wr_ready_o.
    // wr_ready_o depends only on the registered pointers and drops solely when the FIFO is full.
    assign w_empty    = (r_wptr == r_rptr);
    assign w_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_acc      = wr_valid_i && !w_full;
    assign w_wr_ctrl  = w_acc && (wr_addr_i == 4'h0);
    assign w_wr_baud  = w_acc && (wr_addr_i == 4'h8);
    assign w_unmapped = w_acc && (wr_addr_i != 4'h0) && (wr_addr_i != 4'h4) && (wr_addr_i != 4'h8);
    assign w_flush    = w_wr_ctrl && wr_data_i[1];
    assign w_push     = w_acc && (wr_addr_i == 4'h4) && !w_flush;
    assign w_baud_wr  = (wr_data_i[15:0] < 16'd2) ? 16'd2 : wr_data_i[15:0];
    // A flush on this edge wins over handing the head byte to the serialiser.
    assign w_avail    = r_en && !w_empty && !w_flush;
    assign w_bit_end  = (r_cnt == 16'd0);
    assign w_unused   = ^wr_data_i[31:16];

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_shift     = 1'b0;
        w_tx_nxt    = r_tx;
        case (r_state)
            IDLE: begin
                w_tx_nxt = 1'b1;
                if (w_avail) begin
                    w_pop       = 1'b1;
                    w_tx_nxt    = 1'b0;
                    w_state_nxt = START;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_tx_nxt    = r_shift[0];
                    w_shift     = 1'b1;
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    if (r_bit_idx == 3'd7) begin
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = STOP;
                    end else begin
                        w_tx_nxt = r_shift[0];
                        w_shift  = 1'b1;
                    end
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    if (w_avail) begin
                        w_pop       = 1'b1;
                        w_tx_nxt    = 1'b0;
                        w_state_nxt = START;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_en   <= 1'b1;
            r_err  <= 1'b0;
            r_baud <= 16'(CLK_DIV);
        end else begin
            r_err <= w_unmapped;
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_flush) begin
                r_rptr <= r_wptr;
            end else if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_wr_ctrl) r_en <= wr_data_i[0];
            if (w_wr_baud) r_baud <= w_baud_wr;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= wr_data_i[7:0];
    end

    // Baud counter runs div-1 down to 0; zero marks the last cycle of the current bit.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_div     <= 16'(CLK_DIV);
            r_cnt     <= '0;
            r_shift   <= '0;
            r_bit_idx <= '0;
        end else begin
            if (w_pop) begin
                r_div     <= r_baud;
                r_cnt     <= r_baud - 16'd1;
                r_shift   <= r_mem[r_rptr[AW-1:0]];
                r_bit_idx <= '0;
            end else if (r_state != IDLE) begin
                if (w_bit_end) begin
                    r_cnt <= r_div - 16'd1;
                end else begin
                    r_cnt <= r_cnt - 16'd1;
                end
                if (w_shift) r_shift <= {1'b0, r_shift[7:1]};
                if (r_state == DATA && w_bit_end) r_bit_idx <= r_bit_idx + 3'd1;
            end
        end
    end

    assign wr_ready_o  = !w_full;
    assign wr_err_o    = r_err;
    assign tx_o        = r_tx;
    assign busy_o      = (r_state != IDLE) || !w_empty;
    assign level_o     = r_wptr - r_rptr;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer: a frame-level line model checked every cycle,
// plus hand-computed expectations for each scenario.
`timescale 1ns/1ps
module tb_uart_tx_buffer;
    localparam int CLK_DIV = 4;
    localparam int DEPTH   = 16;

    logic        clk_i      = 1'b0;
    logic        rst_n_i    = 1'b1;
    logic        wr_valid_i = 1'b0;
    logic [3:0]  wr_addr_i  = '0;
    logic [31:0] wr_data_i  = '0;
    logic        wr_ready_o;
    logic        wr_err_o;
    logic        tx_o;
    logic        busy_o;
    logic [4:0]  level_o;
    logic [1:0]  dbg_state_o;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_buffer #(.CLK_DIV(CLK_DIV), .DEPTH(DEPTH)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .wr_valid_i  (wr_valid_i),
        .wr_addr_i   (wr_addr_i),
        .wr_data_i   (wr_data_i),
        .wr_ready_o  (wr_ready_o),
        .wr_err_o    (wr_err_o),
        .tx_o        (tx_o),
        .busy_o      (busy_o),
        .level_o     (level_o),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- clock ----------------
    always #5 clk_i = ~clk_i;

    // ---------------- checking helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- write seen by the DUT on the coming edge ----------------
    logic        tb_acc  = 1'b0;
    logic [3:0]  tb_addr = '0;
    logic [31:0] tb_data = '0;

    always @(negedge clk_i) begin
        #2;
        tb_acc  = wr_valid_i && wr_ready_o && rst_n_i;
        tb_addr = wr_addr_i;
        tb_data = wr_data_i;
    end

    // ---------------- line model and per-cycle scoreboard ----------------
    logic [7:0] exp_q[$];
    logic       m_active = 1'b0;
    int         m_t      = 0;
    int         m_div    = CLK_DIV;
    int         m_baud   = CLK_DIV;
    logic       m_en     = 1'b1;
    logic       m_err    = 1'b0;
    logic [9:0] m_frame  = '1;

    always @(negedge clk_i) begin
        logic exp_tx;
        logic flush_now;
        if (!rst_n_i) begin
            exp_q.delete();
            m_active = 1'b0;
            m_t      = 0;
            m_en     = 1'b1;
            m_baud   = CLK_DIV;
            m_err    = 1'b0;
            check("rst_tx", tx_o, 1'b1);
            check("rst_level", level_o, 0);
            check("rst_busy", busy_o, 1'b0);
            check("rst_ready", wr_ready_o, 1'b1);
            check("rst_err", wr_err_o, 1'b0);
        end else begin
            // advance the model across the edge just past
            m_err = 1'b0;
            if (m_active) begin
                m_t++;
                if (m_t == 10 * m_div) m_active = 1'b0;
            end
            flush_now = tb_acc && (tb_addr == 4'h0) && tb_data[1];
            if (!m_active && m_en && exp_q.size() > 0 && !flush_now) begin
                m_frame  = {1'b1, exp_q.pop_front(), 1'b0};
                m_active = 1'b1;
                m_t      = 0;
                m_div    = m_baud;
            end
            if (tb_acc) begin
                case (tb_addr)
                    4'h0: begin
                        m_en = tb_data[0];
                        if (tb_data[1]) exp_q.delete();
                    end
                    4'h4: exp_q.push_back(tb_data[7:0]);
                    4'h8: m_baud = (tb_data[15:0] < 2) ? 2 : int'(tb_data[15:0]);
                    default: m_err = 1'b1;
                endcase
            end
            exp_tx = m_active ? m_frame[m_t / m_div] : 1'b1;
            check("tx", tx_o, exp_tx);
            check("level", level_o, exp_q.size());
            check("busy", busy_o, m_active || exp_q.size() != 0);
            check("ready", wr_ready_o, exp_q.size() < DEPTH);
            check("err", wr_err_o, m_err);
        end
    end

    // ---------------- driver tasks (called at negedge + 1) ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk_i);
            #1;
        end
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d, output int waited);
        waited     = 0;
        wr_valid_i = 1'b1;
        wr_addr_i  = a;
        wr_data_i  = d;
        while (!wr_ready_o && waited < 200) begin
            cyc(1);
            waited++;
        end
        check("wr_accept", wr_ready_o, 1'b1);
        cyc(1);
        wr_valid_i = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        int dummy;
        do_write(a, d, dummy);
    endtask

    task automatic wait_idle(input int limit, output int max_lvl);
        int n;
        n       = 0;
        max_lvl = level_o;
        while (busy_o && n < limit) begin
            cyc(1);
            if (level_o > max_lvl) max_lvl = level_o;
            n++;
        end
        check("idle_reached", busy_o, 1'b0);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        logic [9:0] a5_pat;
        int         waited;
        int         max_lvl;
        int         lows;
        int         f2;
        logic       seen;

        #1 rst_n_i = 1'b0;
        repeat (3) @(negedge clk_i);
        #1 rst_n_i = 1'b1;

        // single byte 0xA5: line 0,1,0,1,0,0,1,0,1,1, four cycles per bit
        a5_pat = 10'b11_0100_1010;
        wr(4'h4, 32'hDEAD_BEA5);
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            check("a5_line", tx_o, a5_pat[i / 4]);
        end
        cyc(1);
        check("a5_busy_end", busy_o, 1'b0);
        check("a5_tx_idle", tx_o, 1'b1);

        // three back-to-back bytes, contiguous frames
        wr(4'h4, 32'h01);
        wr(4'h4, 32'h80);
        wr(4'h4, 32'hFF);
        wait_idle(400, max_lvl);
        check("b2b_peak_level", max_lvl, 2);

        // fill beyond depth while a frame is active
        for (int i = 0; i < 17; i++) wr(4'h4, 32'h30 + i);
        check("fill_level", level_o, 16);
        check("fill_ready_low", wr_ready_o, 1'b0);
        do_write(4'h4, 32'h41, waited);
        check("fill_stall_cycles", waited, 25);
        wait_idle(2000, max_lvl);
        check("fill_peak_level", max_lvl, 16);

        // disable mid-frame, queue two, re-enable
        wr(4'h4, 32'h5A);
        cyc(6);
        wr(4'h0, 32'h0);
        wr(4'h4, 32'h11);
        wr(4'h4, 32'h22);
        cyc(60);
        check("dis_level", level_o, 2);
        check("dis_tx_high", tx_o, 1'b1);
        check("dis_busy", busy_o, 1'b1);
        wr(4'h0, 32'h1);
        wait_idle(400, max_lvl);

        // flush while a frame is in progress
        wr(4'h4, 32'h77);
        wr(4'h4, 32'h88);
        wr(4'h4, 32'h99);
        wr(4'h0, 32'h3);
        check("flush_level", level_o, 0);
        check("flush_frame_on", busy_o, 1'b1);
        wait_idle(200, max_lvl);

        // divisor change mid-frame: next frame 0x00 at clamped divisor 2
        wr(4'h4, 32'hFF);
        cyc(8);
        wr(4'h8, 32'h1);
        wr(4'h4, 32'h00);
        lows = 0;
        f2   = 0;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            cyc(1);
            if (!busy_o) break;
            if (!tx_o) begin
                lows++;
                seen = 1'b1;
            end
            if (seen) f2++;
        end
        check("baud_low_cycles", lows, 18);
        check("baud_frame_len", f2, 20);
        check("baud_idle", busy_o, 1'b0);
        wr(4'h8, 32'h4);

        // unmapped address
        wr(4'hC, 32'h1234_5678);
        check("err_pulse", wr_err_o, 1'b1);
        check("err_level", level_o, 0);
        check("err_busy", busy_o, 1'b0);
        cyc(1);
        check("err_clear", wr_err_o, 1'b0);

        // reset mid-DATA with bytes still queued
        wr(4'h4, 32'h3C);
        wr(4'h4, 32'h55);
        wr(4'h4, 32'h66);
        cyc(7);
        check("pre_rst_tx_low", tx_o, 1'b0);
        check("pre_rst_level", level_o, 2);
        @(negedge clk_i);
        #3 rst_n_i = 1'b0;
        #1;
        check("rst_mid_tx", tx_o, 1'b1);
        check("rst_mid_level", level_o, 0);
        check("rst_mid_busy", busy_o, 1'b0);
        repeat (2) @(negedge clk_i);
        #1 rst_n_i = 1'b1;

        // recovery with default divisor
        wr(4'h4, 32'hC3);
        wait_idle(200, max_lvl);

        cyc(2);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
